fir_sample_sequencer: RTL

Controller that sequences a ready/valid sample stream into one student_fir datapath.
- Accepts one sample, drives the FIR's single-cycle valid strobe, then waits for the FIR's completion strobe.
- Captures the 32-bit result and presents it on a ready/valid output with backpressure.
- Sits between the sample source (ADC/DMA) and the FIR chain; detects a hung FIR with a timeout watchdog.

---
 rtl/fir_seq_pkg.sv | 14 +
 rtl/fir_seq_watchdog.sv | 67 ++++++
 rtl/fir_sample_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared state encoding and default widths for the FIR sample sequencer
package fir_seq_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int ACC_W_DEF    = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } fir_seq_state_e;

endpackage

// File: rtl/fir_seq_watchdog.sv
// rtl/fir_seq_watchdog.sv - WAIT-state cycle counter, timeout compare, worst-latency tracker
// Optional max-latency tracking is built when FIR_SEQ_STATS_EN is defined.
module fir_seq_watchdog
    import fir_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  fir_seq_state_e       state,
    input  logic                 done,
    input  logic                 clr_err,
    output logic                 expire,
    output logic [CNT_W-1:0]     max_latency
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES);

    logic [WCNT_W-1:0] wait_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt <= '0;
        end else if (state == STROBE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A done in the final WAIT cycle takes priority over the abort.
    assign expire = (state == WAIT) && !done && (wait_cnt == WCNT_W'(TIMEOUT_CYCLES - 1));

`ifdef FIR_SEQ_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    logic [WCNT_W:0]    latency;
    logic [CNT_W-1:0]   latency_sat;
    logic [CNT_W-1:0]   max_q;

    // Latency counts the done cycle itself, hence the +1.
    assign latency = {1'b0, wait_cnt} + {{WCNT_W{1'b0}}, 1'b1};

    always_comb begin
        latency_sat = CNT_W'(latency);
        if (32'(latency) > 32'(CNT_ONES)) begin
            latency_sat = CNT_ONES;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            max_q <= '0;
        end else if (clr_err) begin
            max_q <= '0;
        end else if ((state == WAIT) && done && (latency_sat > max_q)) begin
            max_q <= latency_sat;
        end
    end

    assign max_latency = max_q;
`else
    assign max_latency = '0;
`endif

endmodule

// File: rtl/fir_sample_sequencer.sv
// rtl/fir_sample_sequencer.sv - sequences a ready/valid sample stream through one FIR datapath
// Statistics counters are built when FIR_SEQ_STATS_EN is defined.
module fir_sample_sequencer
    import fir_seq_pkg::*;
#(
    parameter int SAMPLE_W       = SAMPLE_W_DEF,
    parameter int ACC_W          = ACC_W_DEF,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [SAMPLE_W-1:0]  s_sample_i,
    output logic                 fir_valid_strobe_o,
    output logic [SAMPLE_W-1:0]  fir_sample_o,
    input  logic                 fir_valid_strobe_i,
    input  logic [ACC_W-1:0]     fir_y_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [ACC_W-1:0]     m_y_o,
    output logic                 busy_o,
    output logic                 timeout_o,
    input  logic                 clr_err_i,
    output logic [CNT_W-1:0]     sample_count_o,
    output logic [CNT_W-1:0]     max_latency_o
);

    fir_seq_state_e state, next_state;
    logic           expire;

    fir_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .state       (state),
        .done        (fir_valid_strobe_i),
        .clr_err     (clr_err_i),
        .expire      (expire),
        .max_latency (max_latency_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (s_valid_i) next_state = STROBE;
            STROBE:  next_state = WAIT;
            WAIT:    if (fir_valid_strobe_i) next_state = HOLD;
                     else if (expire) next_state = IDLE;
            HOLD:    if (m_ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        s_ready_o = (state == IDLE);
        busy_o    = (state != IDLE);
    end

    // Strobe and result-valid are flopped from the next state so each tracks its state exactly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fir_valid_strobe_o <= 1'b0;
            m_valid_o          <= 1'b0;
            fir_sample_o       <= '0;
            m_y_o              <= '0;
            timeout_o          <= 1'b0;
        end else begin
            fir_valid_strobe_o <= (next_state == STROBE);
            m_valid_o          <= (next_state == HOLD);
            if ((state == IDLE) && s_valid_i) begin
                fir_sample_o <= s_sample_i;
            end
            if ((state == WAIT) && fir_valid_strobe_i) begin
                m_y_o <= fir_y_i;
            end
            if (expire) begin
                timeout_o <= 1'b1;
            end else if (clr_err_i) begin
                timeout_o <= 1'b0;
            end
        end
    end

`ifdef FIR_SEQ_STATS_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr_err_i) begin
            count_q <= '0;
        end else if ((state == HOLD) && m_ready_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign sample_count_o = count_q;
`else
    assign sample_count_o = '0;
`endif

endmodule
